// File: rtl/ahb_master_pack.sv
// rtl/ahb_master_pack.sv - shared AHB bus types
package ahb_master_pack;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } t_htrans;

  typedef enum logic [2:0] {
    HBURST_SINGLE, HBURST_INCR, HBURST_WRAP4, HBURST_INCR4,
    HBURST_WRAP8, HBURST_INCR8, HBURST_WRAP16, HBURST_INCR16
  } t_hburst;

  typedef enum logic [2:0] {
    HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD, HSIZE_DWORD,
    HSIZE_4WORD, HSIZE_8WORD, HSIZE_16WORD, HSIZE_32WORD
  } t_hsize;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } t_hresp;

endpackage

// File: rtl/ahb_slave_ram_mem.sv
// rtl/ahb_slave_ram_mem.sv - byte-enabled word RAM with write-to-read bypass
module ahb_slave_ram_mem #(
  parameter int DATA_WDT = 32,
  parameter int WORD_AW  = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [WORD_AW-1:0]    wr_addr,
  input  logic [DATA_WDT/8-1:0] wr_mask,
  input  logic [DATA_WDT-1:0]   wr_data,
  input  logic [WORD_AW-1:0]    rd_addr,
  output logic [DATA_WDT-1:0]   rd_data
);
  localparam int NB = DATA_WDT / 8;

  logic [DATA_WDT-1:0] mem [0:(1 << WORD_AW)-1];
  logic [DATA_WDT-1:0] merged;

  always_comb begin
    merged = mem[wr_addr];
    for (int b = 0; b < NB; b++) begin
      if (wr_mask[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= merged;
  end

  // A read landing on the word being committed this edge sees the merged value.
  assign rd_data = (wr_en && (rd_addr == wr_addr)) ? merged : mem[rd_addr];

endmodule

// File: rtl/ahb_slave_ram.sv
// rtl/ahb_slave_ram.sv - AHB RAM responder with wait states, ERROR and RETRY
module ahb_slave_ram
  import ahb_master_pack::*;
#(
  parameter int DATA_WDT    = 32,
  parameter int MEM_AWDT    = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  t_htrans             i_htrans,
  input  t_hburst             i_hburst,
  input  logic                i_hwrite,
  input  t_hsize              i_hsize,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  input  logic                i_retry_req,
  output logic [DATA_WDT-1:0] o_hrdata,
  output logic                o_hready,
  output t_hresp              o_hresp
);
  localparam int NB        = DATA_WDT / 8;
  localparam int LANE_BITS = $clog2(NB);
  localparam int WORD_AW   = MEM_AWDT - LANE_BITS;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2, ST_RTY1, ST_RTY2, ST_DATA
  } t_state;

  t_state               state;
  logic [3:0]           wait_cnt;
  logic                 retry_armed;
  logic [WORD_AW-1:0]   lat_word;
  logic                 lat_write;
  logic [NB-1:0]        lat_mask;

  logic                 accept;
  logic                 illegal;
  logic                 retry_hit;
  logic                 size_ok;
  logic                 misaligned;
  logic                 out_of_range;
  logic [2:0]           size_bits;
  logic [LANE_BITS-1:0] lane_off;
  logic [NB-1:0]        acc_mask;
  logic [WORD_AW-1:0]   rd_word;
  logic [DATA_WDT-1:0]  rd_data;
  logic                 wr_en;
  logic                 unused_hburst;

  assign unused_hburst = ^i_hburst;

  assign size_bits    = i_hsize;
  assign lane_off     = i_haddr[LANE_BITS-1:0];
  assign out_of_range = |i_haddr[31:MEM_AWDT];
  assign accept       = i_hsel && i_hready &&
                        (i_htrans == HTRANS_NONSEQ || i_htrans == HTRANS_SEQ);

  // A lane belongs to the access when it shares the size-aligned slot of the address.
  always_comb begin
    size_ok    = int'(size_bits) <= LANE_BITS;
    misaligned = ((int'(lane_off) >> size_bits) << size_bits) != int'(lane_off);
    acc_mask   = '0;
    for (int b = 0; b < NB; b++) begin
      acc_mask[b] = ((b >> size_bits) == (int'(lane_off) >> size_bits));
    end
  end

  assign illegal   = !size_ok || misaligned || out_of_range;
  assign retry_hit = retry_armed && (i_htrans == HTRANS_NONSEQ);

  assign wr_en   = (state == ST_DATA) && lat_write;
  assign rd_word = (state == ST_WAIT) ? lat_word : i_haddr[MEM_AWDT-1:LANE_BITS];

  ahb_slave_ram_mem #(
    .DATA_WDT (DATA_WDT),
    .WORD_AW  (WORD_AW)
  ) u_mem (
    .clk     (i_hclk),
    .wr_en   (wr_en),
    .wr_addr (lat_word),
    .wr_mask (lat_mask),
    .wr_data (i_hwdata),
    .rd_addr (rd_word),
    .rd_data (rd_data)
  );

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state       <= ST_IDLE;
      o_hready    <= 1'b1;
      o_hresp     <= HRESP_OKAY;
      o_hrdata    <= '0;
      retry_armed <= 1'b0;
      wait_cnt    <= '0;
      lat_word    <= '0;
      lat_write   <= 1'b0;
      lat_mask    <= '0;
    end else begin
      retry_armed <= retry_armed | i_retry_req;
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state    <= ST_DATA;
            o_hready <= 1'b1;
            if (!lat_write) o_hrdata <= rd_data;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          o_hready <= 1'b1;
        end
        ST_RTY1: begin
          state    <= ST_RTY2;
          o_hready <= 1'b1;
        end
        // IDLE, DATA, ERR2 and RTY2 all drive hready high, so the bus may start a new transfer here.
        default: begin
          state    <= ST_IDLE;
          o_hready <= 1'b1;
          o_hresp  <= HRESP_OKAY;
          if (accept) begin
            lat_word  <= i_haddr[MEM_AWDT-1:LANE_BITS];
            lat_write <= i_hwrite;
            lat_mask  <= acc_mask;
            if (illegal) begin
              state    <= ST_ERR1;
              o_hready <= 1'b0;
              o_hresp  <= HRESP_ERROR;
            end else if (retry_hit) begin
              state       <= ST_RTY1;
              o_hready    <= 1'b0;
              o_hresp     <= HRESP_RETRY;
              retry_armed <= i_retry_req;
            end else if (WAIT_STATES > 0) begin
              state    <= ST_WAIT;
              o_hready <= 1'b0;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= ST_DATA;
              if (!i_hwrite) o_hrdata <= rd_data;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_ram.sv
// tb/tb_ahb_slave_ram.sv - scoreboard bench for ahb_slave_ram at 0, 2 and 3 wait states
module tb_ahb_slave_ram;
  import ahb_master_pack::*;

  localparam int K_OK  = 0;
  localparam int K_ERR = 1;
  localparam int K_RTY = 2;

  typedef struct packed {
    logic [1:0]  kind;
    logic        is_read;
    logic [31:0] data;
    logic [3:0]  known;
    logic [3:0]  lows;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel_v [3];
  logic        retry_v [3];
  logic [31:0] haddr;
  logic [31:0] hwdata;
  t_htrans     htrans;
  t_hburst     hburst;
  logic        hwrite;
  t_hsize      hsize;
  logic        hready_v [3];
  t_hresp      hresp_v [3];
  logic [31:0] hrdata_v [3];

  int          ws_tab [3] = '{0, 2, 3};
  logic [7:0]  ref_mem [3][4096];
  bit          ref_known [3][4096];
  bit          armed [3];
  exp_t        q [$];
  int          act = 0;
  int          cyc = 0;
  int          low_cnt = 0;
  int          last_pop_cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_slave_ram #(
      .DATA_WDT    (32),
      .MEM_AWDT    (12),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .i_hclk      (clk),
      .i_hreset_n  (rst_n),
      .i_hsel      (hsel_v[g]),
      .i_haddr     (haddr),
      .i_htrans    (htrans),
      .i_hburst    (hburst),
      .i_hwrite    (hwrite),
      .i_hsize     (hsize),
      .i_hwdata    (hwdata),
      .i_hready    (hready_v[g]),
      .i_retry_req (retry_v[g]),
      .o_hrdata    (hrdata_v[g]),
      .o_hready    (hready_v[g]),
      .o_hresp     (hresp_v[g])
    );
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Expected response computed from the byte-level memory model, then the address phase is driven.
  task automatic issue(input int k, input t_htrans trans, input logic wr, input logic [31:0] addr,
                       input t_hsize size, input logic [31:0] wdata, input t_hburst burst);
    exp_t e;
    int   nb;
    int   a;
    bit   ok;
    nb = 1 << int'(size);
    e = '0;
    if (addr >= 32'd4096 || nb > 4 || (addr % nb) != 0) begin
      e.kind = K_ERR;
      e.lows = 4'd1;
    end else if (trans == HTRANS_NONSEQ && armed[k]) begin
      e.kind = K_RTY;
      e.lows = 4'd1;
      armed[k] = 1'b0;
    end else begin
      e.kind = K_OK;
      e.lows = 4'(ws_tab[k]);
      e.is_read = !wr;
      if (wr) begin
        for (int i = 0; i < nb; i++) begin
          a = int'(addr) + i;
          ref_mem[k][a] = wdata[8*(a%4) +: 8];
          ref_known[k][a] = 1'b1;
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          a = int'(addr & ~32'd3) + i;
          e.data[8*i +: 8] = ref_mem[k][a];
          e.known[i] = ref_known[k][a];
        end
      end
    end
    hsel_v[k] = 1'b1;
    haddr = addr;
    htrans = trans;
    hwrite = wr;
    hsize = size;
    hburst = burst;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = hready_v[k];
      @(posedge clk);
      #1;
    end
    hsel_v[k] = 1'b0;
    htrans = HTRANS_IDLE;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: addr %h not accepted by dut %0d", addr, k);
    end else begin
      hwdata = wdata;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (q.size() != 0 && c < 100) begin
      sync();
      c++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding", q.size());
      q.delete();
    end
  endtask

  task automatic pulse_retry(input int k);
    retry_v[k] = 1'b1;
    armed[k] = 1'b1;
    sync();
    retry_v[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    t_hresp      want;
    logic [31:0] m;
    if (rst_n && q.size() > 0) begin
      e = q[0];
      want = (e.kind == 2'(K_ERR)) ? HRESP_ERROR :
             (e.kind == 2'(K_RTY)) ? HRESP_RETRY : HRESP_OKAY;
      check("hresp", 32'(hresp_v[act]), 32'(want));
      if (!hready_v[act]) begin
        low_cnt++;
        if (low_cnt > 20) begin
          check("stall_bound", low_cnt, 32'(e.lows));
          void'(q.pop_front());
          low_cnt = 0;
        end
      end else begin
        void'(q.pop_front());
        check("wait_cycles", low_cnt, 32'(e.lows));
        if (e.is_read && e.known != 4'd0) begin
          for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{e.known[i]}};
          check("hrdata", hrdata_v[act] & m, e.data & m);
        end
        low_cnt = 0;
        last_pop_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    int          k;
    int          size_i;
    logic [31:0] addr;
    t_htrans     tr;
    for (int g = 0; g < 3; g++) begin
      hsel_v[g] = 1'b0;
      retry_v[g] = 1'b0;
      armed[g] = 1'b0;
    end
    haddr = '0;
    hwdata = '0;
    htrans = HTRANS_IDLE;
    hburst = HBURST_SINGLE;
    hwrite = 1'b0;
    hsize = HSIZE_WORD;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_hready", 32'(hready_v[g]), 32'd1);
      check("rst_hresp", 32'(hresp_v[g]), 32'(HRESP_OKAY));
      check("rst_hrdata", hrdata_v[g], 32'd0);
    end
    rst_n = 1'b1;
    sync();

    // Zero-wait write then read-back on consecutive edges exercises the bypass.
    act = 0;
    issue(0, HTRANS_NONSEQ, 1'b1, 32'h040, HSIZE_WORD, 32'hDEADBEEF, HBURST_SINGLE);
    issue(0, HTRANS_NONSEQ, 1'b0, 32'h040, HSIZE_WORD, 32'h0, HBURST_SINGLE);
    issue(0, HTRANS_NONSEQ, 1'b1, 32'h040, HSIZE_WORD, 32'h11223344, HBURST_SINGLE);
    issue(0, HTRANS_NONSEQ, 1'b1, 32'h041, HSIZE_BYTE, 32'h0000AA00, HBURST_SINGLE);
    issue(0, HTRANS_NONSEQ, 1'b0, 32'h040, HSIZE_WORD, 32'h0, HBURST_SINGLE);
    drain();

    issue(0, HTRANS_NONSEQ, 1'b0, 32'h2000, HSIZE_WORD, 32'h0, HBURST_SINGLE);
    drain();
    @(negedge clk);
    check("post_err_hready", 32'(hready_v[0]), 32'd1);
    check("post_err_hresp", 32'(hresp_v[0]), 32'(HRESP_OKAY));
    sync();

    issue(0, HTRANS_NONSEQ, 1'b1, 32'h010, HSIZE_WORD, 32'hCAFE0000, HBURST_SINGLE);
    drain();
    pulse_retry(0);
    issue(0, HTRANS_NONSEQ, 1'b1, 32'h010, HSIZE_WORD, 32'h5, HBURST_SINGLE);
    drain();
    issue(0, HTRANS_NONSEQ, 1'b0, 32'h010, HSIZE_WORD, 32'h0, HBURST_SINGLE);
    issue(0, HTRANS_NONSEQ, 1'b1, 32'h010, HSIZE_WORD, 32'h5, HBURST_SINGLE);
    issue(0, HTRANS_NONSEQ, 1'b0, 32'h010, HSIZE_WORD, 32'h0, HBURST_SINGLE);
    drain();

    act = 1;
    for (int i = 0; i < 4; i++)
      issue(1, HTRANS_NONSEQ, 1'b1, 32'h100 + 32'(4*i), HSIZE_WORD, $urandom, HBURST_SINGLE);
    drain();
    issue(1, HTRANS_NONSEQ, 1'b0, 32'h100, HSIZE_WORD, 32'h0, HBURST_INCR4);
    c0 = cyc;
    for (int i = 1; i < 4; i++)
      issue(1, HTRANS_SEQ, 1'b0, 32'h100 + 32'(4*i), HSIZE_WORD, 32'h0, HBURST_INCR4);
    drain();
    check("incr4_cycles", last_pop_cyc - c0 + 1, 32'd12);

    // Reset lands while the write to 0x080 is still in its wait states.
    act = 2;
    issue(2, HTRANS_NONSEQ, 1'b1, 32'h080, HSIZE_WORD, 32'h11111111, HBURST_SINGLE);
    drain();
    hsel_v[2] = 1'b1;
    haddr = 32'h080;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b1;
    hsize = HSIZE_WORD;
    sync();
    hsel_v[2] = 1'b0;
    htrans = HTRANS_IDLE;
    hwdata = 32'h22222222;
    check("wait_entered", 32'(hready_v[2]), 32'd0);
    sync();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_wait_hready", 32'(hready_v[2]), 32'd1);
    check("rst_wait_hresp", 32'(hresp_v[2]), 32'(HRESP_OKAY));
    @(negedge clk);
    rst_n = 1'b1;
    for (int g = 0; g < 3; g++) armed[g] = 1'b0;
    sync();
    issue(2, HTRANS_NONSEQ, 1'b0, 32'h080, HSIZE_WORD, 32'h0, HBURST_SINGLE);
    drain();

    for (int blk = 0; blk < 15; blk++) begin
      k = blk % 3;
      act = k;
      for (int n = 0; n < 20; n++) begin
        if ($urandom_range(0, 9) == 0) begin
          pulse_retry(k);
          size_i = $urandom_range(0, 2);
          addr = 32'($urandom_range(0, 255)) & ~((32'd1 << size_i) - 32'd1);
          tr = HTRANS_NONSEQ;
        end else begin
          size_i = $urandom_range(0, 3);
          addr = 32'($urandom_range(0, 255));
          if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size_i) - 32'd1);
          if ($urandom_range(0, 19) == 0) addr = addr | (32'h1000 << $urandom_range(0, 19));
          tr = ($urandom_range(0, 1) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        end
        issue(k, tr, 1'($urandom_range(0, 1)), addr, t_hsize'(size_i), $urandom, HBURST_INCR);
        if ($urandom_range(0, 4) == 0) sync();
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
